spi_arbiter: RTL and testbench

Round-robin scheduler that shares one `spi` master between NUM_REQ requesters, for example per-axis stepper-driver register accessors.
- Runs on the divided SPI clock, so it is cycle-aligned with the `spi` frame counter.
- Sequences `send_enable_in`, `data_in` and `cs_select_in` of the `spi` instance.
- Returns the received datagram to the granted requester with a one-cycle acknowledge.
- Requester i is hard-mapped to chip select i.

---
 rtl/spi_arbiter_pkg.sv | 15 +
 rtl/spi_arbiter_rr_arbiter.sv | 30 +++
 rtl/spi_arbiter.sv | 168 ++++++++++++++++
 tb/tb_spi_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the SPI requester arbiter: FSM encoding and the
// datagram/chip-select defaults that must agree with the spi master.
package spi_arbiter_pkg;

    localparam int DEF_SIZE    = 40;
    localparam int DEF_CS_SIZE = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/spi_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [IDX_W-1:0]   ptr_in,
    output logic [NUM_REQ-1:0] grant_out,
    output logic [IDX_W-1:0]   idx_out,
    output logic               valid_out
);

    always_comb begin
        int c;
        c         = 0;
        grant_out = '0;
        idx_out   = '0;
        valid_out = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = (int'(ptr_in) + k) % NUM_REQ;
            if (!valid_out && req_in[IDX_W'(c)]) begin
                valid_out             = 1'b1;
                idx_out               = IDX_W'(c);
                grant_out[IDX_W'(c)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin sharing of one spi master among NUM_REQ requesters; runs on the
// divided SPI clock so XFER counts line up with the spi frame counter.
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int SIZE          = DEF_SIZE,
    parameter int CS_SIZE       = DEF_CS_SIZE,
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 15
) (
    input  logic                        internal_clk,
    input  logic                        reset_n_in,
    input  logic [NUM_REQ-1:0]          req_in,
    input  logic [NUM_REQ*SIZE-1:0]     req_data_in,
    output logic [NUM_REQ-1:0]          ack_out,
    output logic                        err_out,
    output logic [SIZE-1:0]             resp_data_out,
    output logic                        busy_out,
    output logic [SIZE-1:0]             spi_data_out,
    output logic                        spi_send_enable_out,
    output logic [$clog2(CS_SIZE)-1:0]  spi_cs_select_out,
    input  logic                        spi_ready_in,
    input  logic [SIZE-1:0]             spi_data_in
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CS_W  = $clog2(CS_SIZE);
    localparam int CNT_W = $clog2(SIZE+3) + 1;
    localparam int TO_W  = $clog2(START_TIMEOUT+1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [SIZE-1:0]     spi_data_q, spi_data_d;
    logic [CS_W-1:0]     cs_q, cs_d;
    logic                en_q, en_d;
    logic                busy_q, busy_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                err_q, err_d;
    logic [SIZE-1:0]     resp_q, resp_d;

    logic [NUM_REQ-1:0]  win_grant;
    logic [IDX_W-1:0]    win_idx;
    logic                win_valid;
    logic [IDX_W-1:0]    ptr_next;
    logic [SIZE-1:0]     req_words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign req_words[g] = req_data_in[g*SIZE +: SIZE];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_in    (req_in),
        .ptr_in    (ptr_q),
        .grant_out (win_grant),
        .idx_out   (win_idx),
        .valid_out (win_valid)
    );

    // The finished requester drops to lowest priority on the next round.
    assign ptr_next = (gidx_q == IDX_W'(NUM_REQ-1)) ? '0 : gidx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        cnt_d      = cnt_q;
        to_d       = to_q;
        spi_data_d = spi_data_q;
        cs_d       = cs_q;
        en_d       = en_q;
        busy_d     = busy_q;
        ack_d      = '0;
        err_d      = 1'b0;
        resp_d     = resp_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid && spi_ready_in) begin
                    gidx_d     = win_idx;
                    spi_data_d = req_words[win_idx];
                    cs_d       = CS_W'(win_idx);
                    en_d       = 1'b1;
                    busy_d     = 1'b1;
                    to_d       = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (!spi_ready_in) begin
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end else if (to_q == TO_W'(START_TIMEOUT-1)) begin
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    ack_d   = NUM_REQ'(1) << gidx_q;
                    err_d   = 1'b1;
                    ptr_d   = ptr_next;
                    state_d = ST_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_XFER: begin
                cnt_d = cnt_q + 1'b1;
                // Enable must be gone before the spi counter wraps to idle,
                // otherwise it launches a second frame.
                if (cnt_q == CNT_W'(SIZE+1)) begin
                    en_d    = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (spi_ready_in) begin
                    resp_d  = spi_data_in;
                    ack_d   = NUM_REQ'(1) << gidx_q;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge internal_clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gidx_q     <= '0;
            cnt_q      <= '0;
            to_q       <= '0;
            spi_data_q <= '0;
            cs_q       <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            resp_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            spi_data_q <= spi_data_d;
            cs_q       <= cs_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            resp_q     <= resp_d;
        end
    end

    assign ack_out             = ack_q;
    assign err_out             = err_q;
    assign resp_data_out       = resp_q;
    assign busy_out            = busy_q;
    assign spi_data_out        = spi_data_q;
    assign spi_send_enable_out = en_q;
    assign spi_cs_select_out   = cs_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a small loopback model of the spi master.
module tb_spi_arbiter;

    localparam int SIZE    = 40;
    localparam int CS_SIZE = 4;
    localparam int NREQ    = 4;
    localparam int TO      = 15;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*SIZE-1:0] req_data = '0;
    logic [NREQ-1:0]      ack_out;
    logic                 err_out;
    logic [SIZE-1:0]      resp_data_out;
    logic                 busy_out;
    logic [SIZE-1:0]      spi_data_out;
    logic                 spi_en;
    logic [1:0]           cs_sel;
    logic                 spi_ready;
    logic [SIZE-1:0]      spi_rx;

    int checks = 0;
    int errors = 0;
    int cs_falls = 0;
    logic force_rdy = 1'b0;

    always #5 clk = ~clk;

    spi_arbiter #(.SIZE(SIZE), .CS_SIZE(CS_SIZE), .NUM_REQ(NREQ), .START_TIMEOUT(TO)) dut (
        .internal_clk        (clk),
        .reset_n_in          (rst_n),
        .req_in              (req),
        .req_data_in         (req_data),
        .ack_out             (ack_out),
        .err_out             (err_out),
        .resp_data_out       (resp_data_out),
        .busy_out            (busy_out),
        .spi_data_out        (spi_data_out),
        .spi_send_enable_out (spi_en),
        .spi_cs_select_out   (cs_sel),
        .spi_ready_in        (spi_ready),
        .spi_data_in         (spi_rx)
    );

    // spi model: frame counter 0..SIZE+3, CS low on counts 1..SIZE, restarts
    // if enable is still high when it returns to idle; loops tx back to rx.
    logic            m_busy;
    int              m_cnt;
    logic [SIZE-1:0] m_tx;
    logic            cs_n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_tx   <= '0;
            spi_rx <= '0;
        end else if (!m_busy) begin
            if (spi_en) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_tx   <= spi_data_out;
            end
        end else if (m_cnt == SIZE+3) begin
            spi_rx <= m_tx;
            if (spi_en) begin
                m_cnt <= 0;
                m_tx  <= spi_data_out;
            end else begin
                m_busy <= 1'b0;
            end
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    assign cs_n      = !(m_busy && m_cnt >= 1 && m_cnt <= SIZE);
    assign spi_ready = force_rdy | !m_busy;

    always @(negedge cs_n) cs_falls <= cs_falls + 1;

    function automatic logic [SIZE-1:0] word(input int i);
        return {8'hC0 + 8'(i), 32'hDEAD_0000 + 32'(i)};
    endfunction

    task automatic wait_busy();
        int cyc;
        cyc = 0;
        while (!busy_out && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!busy_out) begin
            errors++;
            $display("FAIL grant_timeout busy=%0b expected 1", busy_out);
        end
    endtask

    task automatic wait_ack(output logic [NREQ-1:0] a, output logic e, output int cyc);
        cyc = 0;
        while (ack_out == '0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        a = ack_out;
        e = err_out;
        checks++;
        if (ack_out == '0) begin
            errors++;
            $display("FAIL ack_timeout ack=%b expected nonzero", ack_out);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack_out, err_out, busy_out, spi_en, cs_sel} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b expected 0", {ack_out, err_out, busy_out, spi_en, cs_sel});
        end
        checks++;
        if (spi_data_out !== '0 || resp_data_out !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h/%h expected 0/0", spi_data_out, resp_data_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [NREQ-1:0] a;
        logic e;
        int cyc, f0, extra;
        req_data[SIZE-1:0] = 40'hA5_0000_0001;
        req = 4'b0001;
        wait_busy();
        f0 = cs_falls;
        checks++;
        if (cs_sel !== 2'd0 || spi_data_out !== 40'hA5_0000_0001) begin
            errors++;
            $display("FAIL single_grant cs=%0d data=%h expected 0/a500000001", cs_sel, spi_data_out);
        end
        wait_ack(a, e, cyc);
        req = '0;
        checks++;
        if (a !== 4'b0001 || e !== 1'b0) begin
            errors++;
            $display("FAIL single_ack ack=%b err=%b expected 0001/0", a, e);
        end
        checks++;
        if (resp_data_out !== 40'hA5_0000_0001) begin
            errors++;
            $display("FAIL single_resp got=%h expected a500000001", resp_data_out);
        end
        checks++;
        if (cyc != 46 || cs_falls - f0 != 1) begin
            errors++;
            $display("FAIL single_frame cycles=%0d cs_falls=%0d expected 46/1", cyc, cs_falls - f0);
        end
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack_out != '0 || busy_out) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL single_once extra_activity=%0d expected 0", extra);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] a;
        logic e;
        int cyc, f0, exp_i;
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[i*SIZE +: SIZE] = word(i);
        req = 4'b1111;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_i = k % NREQ;
            wait_busy();
            f0 = cs_falls;
            checks++;
            if (cs_sel !== 2'(exp_i)) begin
                errors++;
                $display("FAIL rr_grant%0d cs=%0d expected %0d", k, cs_sel, exp_i);
            end
            wait_ack(a, e, cyc);
            if (k == 4) req = '0;
            checks++;
            if (a !== 4'(1 << exp_i) || e !== 1'b0 || resp_data_out !== word(exp_i)) begin
                errors++;
                $display("FAIL rr_ack%0d ack=%b err=%b resp=%h expected %b/0/%h",
                         k, a, e, resp_data_out, 4'(1 << exp_i), word(exp_i));
            end
            checks++;
            if (cs_falls - f0 != 1) begin
                errors++;
                $display("FAIL rr_cs_falls%0d got=%0d expected 1", k, cs_falls - f0);
            end
        end
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] a;
        logic e;
        int cyc;
        logic [SIZE-1:0] prev;
        prev = resp_data_out;
        force_rdy = 1'b1;
        req = 4'b0100;
        wait_busy();
        wait_ack(a, e, cyc);
        req = '0;
        checks++;
        if (a !== 4'b0100 || e !== 1'b1 || spi_en !== 1'b0) begin
            errors++;
            $display("FAIL timeout_ack ack=%b err=%b en=%b expected 0100/1/0", a, e, spi_en);
        end
        checks++;
        if (cyc != TO || resp_data_out !== prev) begin
            errors++;
            $display("FAIL timeout_timing cycles=%0d resp=%h expected %0d/%h", cyc, resp_data_out, TO, prev);
        end
        repeat (80) @(negedge clk);
        force_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] a;
        logic e;
        int cyc;
        req = 4'b1111;
        wait_busy();
        checks++;
        if (cs_sel !== 2'd3) begin
            errors++;
            $display("FAIL midrst_pre cs=%0d expected 3", cs_sel);
        end
        repeat (22) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ack_out, err_out, busy_out, spi_en, cs_sel} !== '0 ||
            spi_data_out !== '0 || resp_data_out !== '0) begin
            errors++;
            $display("FAIL midrst_outputs ctrl=%b data=%h resp=%h expected 0",
                     {ack_out, err_out, busy_out, spi_en, cs_sel}, spi_data_out, resp_data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_busy();
        req = '0;
        checks++;
        if (cs_sel !== 2'd0) begin
            errors++;
            $display("FAIL midrst_first cs=%0d expected 0", cs_sel);
        end
        wait_ack(a, e, cyc);
        checks++;
        if (a !== 4'b0001 || resp_data_out !== word(0)) begin
            errors++;
            $display("FAIL midrst_ack ack=%b resp=%h expected 0001/%h", a, resp_data_out, word(0));
        end
    endtask

    task automatic test_drop();
        logic [NREQ-1:0] a;
        logic e;
        int cyc, f0;
        @(negedge clk);
        req = 4'b0100;
        wait_busy();
        f0 = cs_falls;
        repeat (7) @(negedge clk);
        req = 4'b0010;
        wait_ack(a, e, cyc);
        checks++;
        if (a !== 4'b0100 || e !== 1'b0 || resp_data_out !== word(2) || cs_falls - f0 != 1) begin
            errors++;
            $display("FAIL drop_ack ack=%b err=%b resp=%h falls=%0d expected 0100/0/%h/1",
                     a, e, resp_data_out, cs_falls - f0, word(2));
        end
        wait_busy();
        req = '0;
        checks++;
        if (cs_sel !== 2'd1) begin
            errors++;
            $display("FAIL drop_next cs=%0d expected 1", cs_sel);
        end
        wait_ack(a, e, cyc);
        checks++;
        if (a !== 4'b0010 || resp_data_out !== word(1)) begin
            errors++;
            $display("FAIL drop_next_ack ack=%b resp=%h expected 0010/%h", a, resp_data_out, word(1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
